oai_response_checker: RTL and testbench
=======================================

Name: oai_response_checker

Overview:
- Clocked, synthesizable response checker that sits directly downstream of the OAI cell and its exhaustive a/b/c/d stimulus source.
- Captures each applied input vector and waits a programmable settle time. Then samples the cell output y and compares it to the OAI22 golden function y = ~((a|b)&(c|d)).
- Accumulates vector count, error count, truth-table coverage and an overall pass/fail verdict for the cell characterisation run.

Parameters:
- NUM_VEC, 16, number of vectors checked before the run ends; legal range 1..2^CNT_W-1.
- SETTLE_CYC, 2, clock cycles waited after vector capture before y is sampled; 0 means sample on the next edge.
- CNT_W, 8, width of the vector and error counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  single-cycle pulse; clears all results and arms a new run.
- vec_valid  input  1  high for one cycle when a, b, c, d hold a newly applied vector.
- a  input  1  stimulus bit 3 (MSB of vector index).
- b  input  1  stimulus bit 2.
- c  input  1  stimulus bit 1.
- d  input  1  stimulus bit 0.
- y  input  1  OAI cell output under test.
- busy  output  1  high in ARMED or SETTLE.
- done  output  1  high in DONE.
- pass  output  1  verdict; valid only while done=1.
- vec_cnt  output  CNT_W  vectors checked so far.
- err_cnt  output  CNT_W  mismatches so far; saturates at all-ones.
- cov_mask  output  16  bit i set once vector index {a,b,c,d}=i has been checked.
- overrun  output  1  sticky; vec_valid arrived while a check was pending.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; all outputs 0; counters, cov_mask, overrun and the captured vector cleared. Reset overrides start. Reset mid-run aborts with no partial verdict.
- States: IDLE, ARMED, SETTLE, DONE.
- start=1 in any state clears vec_cnt, err_cnt, cov_mask and overrun, then goes to ARMED next cycle. If start and vec_valid coincide, start wins and the vector is dropped.
- IDLE: waits for start. vec_valid is ignored and does not set overrun.
- ARMED: on vec_valid, latch vec_r={a,b,c,d}, load settle counter with SETTLE_CYC, go to SETTLE.
- SETTLE: if counter≠0, decrement. If counter=0, sample y and compare it against the expected value computed from vec_r, not from the live a..d. Same edge updates:
  - vec_cnt+1;
  - err_cnt+1 on mismatch, saturating;
  - cov_mask[vec_r]=1.
- After the compare: if the new vec_cnt equals NUM_VEC, go to DONE; otherwise go to ARMED.
- Timing: vector captured at edge N; y sampled and counters updated at edge N+1+SETTLE_CYC. A new vec_valid is accepted from the cycle after the compare edge.
- vec_valid during SETTLE: vector ignored, overrun set (sticky until start/reset), check in progress unaffected.
- DONE: done=1. pass=1 iff err_cnt=0 AND cov_mask=16'hFFFF AND overrun=0. State and results hold until start or reset. vec_valid is ignored.
- Outputs are registered; pass is 0 outside DONE.

Optional Feature:
- Macro: OAI_CHK_FIRSTFAIL_EN.
- When defined, add two registered outputs:
  - ff_vec, 4 bits;
  - ff_idx, CNT_W bits.
  Plus ff_valid, 1 bit.
- On the first mismatch after start, capture vec_r into ff_vec and the pre-increment vec_cnt into ff_idx, and set ff_valid. Later mismatches do not overwrite them.
- start and reset clear all three.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Golden run, defaults: start, then 16 vectors 0000..1111 each with a correct y model, one vec_valid every 4 cycles -> done=1, vec_cnt=16, err_cnt=0, cov_mask=FFFF, pass=1, overrun=0.
- y stuck at 0, same 16 vectors -> err_cnt=7 (indices 0,1,2,3,4,8,12), pass=0; with OAI_CHK_FIRSTFAIL_EN, ff_valid=1, ff_vec=0000, ff_idx=0.
- Overrun: second vec_valid one cycle after the first with SETTLE_CYC=2 -> overrun=1, only the first vector counted, final pass=0 even with err_cnt=0.
- Coverage hole: 16 vectors all 0000 with correct y -> err_cnt=0, cov_mask=0001, pass=0.
- Latency: SETTLE_CYC=0; y toggled wrong only on the cycle after capture -> counted as an error; SETTLE_CYC=2 with y correct by then -> no error.
- Reset/restart: rst_n=0 after 5 vectors -> all outputs 0, IDLE. start pulse mid-SETTLE -> counters cleared, ARMED, pending check discarded; a subsequent full golden run gives pass=1.

Source files
------------

// File: rtl/oai_response_checker.sv
// oai_response_checker
// Response checker for an OAI22 cell under exhaustive a/b/c/d stimulus.
// Each accepted vector is held for SETTLE_CYC cycles. The cell output y is
// then compared against ~((a|b)&(c|d)), evaluated on the captured vector.
// The checker accumulates vector count, error count, truth-table coverage and
// a pass/fail verdict.
// Optional feature: define OAI_CHK_FIRSTFAIL_EN to add first-failure capture
// outputs (ff_vec, ff_idx, ff_valid).
module oai_response_checker #(
  parameter int NUM_VEC    = 16,
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [15:0]      cov_mask,
`ifdef OAI_CHK_FIRSTFAIL_EN
  output logic [3:0]       ff_vec,
  output logic [CNT_W-1:0] ff_idx,
  output logic             ff_valid,
`endif
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARMED, SETTLE, DONE} state_t;

  // Settle counter is wide enough to hold SETTLE_CYC; at least one bit.
  localparam int SET_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);

  // Golden OAI22 response for vector {a,b,c,d}.
  function automatic logic oai22_exp(input logic [3:0] v);
    return ~((v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // Saturating increment; the counter holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + 1'b1;
  endfunction

  state_t           state;
  state_t           state_nx;
  logic [3:0]       vec_r;
  logic [SET_W-1:0] settle_cnt;
  logic [CNT_W-1:0] vec_cnt_inc;
  logic             cmp_now;
  logic             mismatch;
  logic             last_vec;

  assign cmp_now     = (state == SETTLE) && (settle_cnt == '0);
  assign mismatch    = (y != oai22_exp(vec_r));
  assign vec_cnt_inc = vec_cnt + 1'b1;
  assign last_vec    = (vec_cnt_inc == LAST_CNT);

  // State register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; start re-arms from any state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      ARMED:   if (vec_valid) state_nx = SETTLE;
      SETTLE:  if (cmp_now) state_nx = last_vec ? DONE : ARMED;
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = ARMED;
  end

  // Status outputs decoded from registered state and result registers only.
  always_comb begin
    busy = (state == ARMED) || (state == SETTLE);
    done = (state == DONE);
    pass = (state == DONE) && (err_cnt == '0) && (cov_mask == 16'hFFFF) && !overrun;
  end

  // Vector capture, settle timing and result accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vec_r      <= '0;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      err_cnt    <= '0;
      cov_mask   <= '0;
      overrun    <= 1'b0;
    end else if (start) begin
      vec_cnt    <= '0;
      err_cnt    <= '0;
      cov_mask   <= '0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (vec_valid) begin
            vec_r      <= {a, b, c, d};
            settle_cnt <= SET_LOAD;
          end
        end
        SETTLE: begin
          // A vector arriving while a check is pending is dropped but flagged.
          if (vec_valid) overrun <= 1'b1;
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
          end else begin
            vec_cnt         <= vec_cnt_inc;
            cov_mask[vec_r] <= 1'b1;
            if (mismatch) err_cnt <= sat_inc(err_cnt);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef OAI_CHK_FIRSTFAIL_EN
  // First-failure capture: only the earliest mismatch of a run is kept.
  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      ff_vec   <= '0;
      ff_idx   <= '0;
      ff_valid <= 1'b0;
    end else if (cmp_now && mismatch && !ff_valid) begin
      ff_vec   <= vec_r;
      ff_idx   <= vec_cnt;
      ff_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_oai_response_checker.sv
// tb_oai_response_checker
// Directed bench for oai_response_checker. Main instance uses defaults
// (NUM_VEC=16, SETTLE_CYC=2); a second instance uses SETTLE_CYC=0.
// Set OAI_CHK_FIRSTFAIL_EN to also check first-failure capture.
module tb_oai_response_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, vec_valid, a, b, c, d, y;
  logic       busy, done, pass, overrun;
  logic [7:0] vec_cnt, err_cnt;
  logic [15:0] cov_mask;
`ifdef OAI_CHK_FIRSTFAIL_EN
  logic [3:0] ff_vec;
  logic [7:0] ff_idx;
  logic       ff_valid;
  logic [3:0] ff_vec0;
  logic [7:0] ff_idx0;
  logic       ff_valid0;
`endif

  logic       start0, vec_valid0, a0, b0, c0, d0, y0;
  logic       busy0, done0, pass0, overrun0;
  logic [7:0] vec_cnt0, err_cnt0;
  logic [15:0] cov_mask0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  oai_response_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid),
    .a(a), .b(b), .c(c), .d(d), .y(y),
    .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .cov_mask(cov_mask),
`ifdef OAI_CHK_FIRSTFAIL_EN
    .ff_vec(ff_vec), .ff_idx(ff_idx), .ff_valid(ff_valid),
`endif
    .overrun(overrun)
  );

  oai_response_checker #(.NUM_VEC(4), .SETTLE_CYC(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .vec_valid(vec_valid0),
    .a(a0), .b(b0), .c(c0), .d(d0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0),
    .vec_cnt(vec_cnt0), .err_cnt(err_cnt0), .cov_mask(cov_mask0),
`ifdef OAI_CHK_FIRSTFAIL_EN
    .ff_vec(ff_vec0), .ff_idx(ff_idx0), .ff_valid(ff_valid0),
`endif
    .overrun(overrun0)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic oai(input logic [3:0] v);
    return ~((v[3] | v[2]) & (v[1] | v[0]));
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One vector every 4 cycles; y held at yv through the compare edge.
  task automatic apply_vec(input logic [3:0] v, input logic yv);
    {a, b, c, d} = v;
    y = yv;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic golden_vecs(input int first, input int n);
    for (int i = first; i < first + n; i++) apply_vec(4'(i), oai(4'(i)));
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_done"}, 32'(done), 32'd0);
    check_eq({tag, "_pass"}, 32'(pass), 32'd0);
    check_eq({tag, "_vec"},  32'(vec_cnt), 32'd0);
    check_eq({tag, "_err"},  32'(err_cnt), 32'd0);
    check_eq({tag, "_cov"},  32'(cov_mask), 32'd0);
    check_eq({tag, "_ovr"},  32'(overrun), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_valid = 1'b0;
    {a, b, c, d} = 4'h0; y = 1'b0;
    start0 = 1'b0; vec_valid0 = 1'b0; {a0, b0, c0, d0} = 4'h0; y0 = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state, and vec_valid ignored in IDLE
    check_idle("rst");
    check_eq("rst_err0", 32'(err_cnt0), 32'd0);
    apply_vec(4'h3, 1'b0);
    check_idle("idle_vv");

    // Golden run
    pulse_start();
    check_eq("armed_busy", 32'(busy), 32'd1);
    golden_vecs(0, 16);
    check_eq("gold_done", 32'(done), 32'd1);
    check_eq("gold_busy", 32'(busy), 32'd0);
    check_eq("gold_vec",  32'(vec_cnt), 32'd16);
    check_eq("gold_err",  32'(err_cnt), 32'd0);
    check_eq("gold_cov",  32'(cov_mask), 32'hFFFF);
    check_eq("gold_ovr",  32'(overrun), 32'd0);
    check_eq("gold_pass", 32'(pass), 32'd1);
    // DONE ignores vec_valid
    apply_vec(4'h0, 1'b0);
    check_eq("done_hold_vec", 32'(vec_cnt), 32'd16);
    check_eq("done_hold_ovr", 32'(overrun), 32'd0);
    check_eq("done_hold_pass", 32'(pass), 32'd1);

    // y stuck at 0: errors on indices 0,1,2,3,4,8,12
    pulse_start();
    check_eq("restart_vec", 32'(vec_cnt), 32'd0);
    for (int i = 0; i < 16; i++) apply_vec(4'(i), 1'b0);
    check_eq("sa0_done", 32'(done), 32'd1);
    check_eq("sa0_err",  32'(err_cnt), 32'd7);
    check_eq("sa0_cov",  32'(cov_mask), 32'hFFFF);
    check_eq("sa0_pass", 32'(pass), 32'd0);
`ifdef OAI_CHK_FIRSTFAIL_EN
    check_eq("sa0_ffv",   32'(ff_valid), 32'd1);
    check_eq("sa0_ffvec", 32'(ff_vec), 32'd0);
    check_eq("sa0_ffidx", 32'(ff_idx), 32'd0);
`endif

    // Overrun: second vec_valid one cycle after the first
    pulse_start();
`ifdef OAI_CHK_FIRSTFAIL_EN
    check_eq("ff_clr", 32'(ff_valid), 32'd0);
`endif
    {a, b, c, d} = 4'h0; y = 1'b1; vec_valid = 1'b1;
    tick();
    {a, b, c, d} = 4'h5;
    tick();
    vec_valid = 1'b0;
    tick(); tick();
    check_eq("ovr_flag", 32'(overrun), 32'd1);
    check_eq("ovr_vec",  32'(vec_cnt), 32'd1);
    check_eq("ovr_err",  32'(err_cnt), 32'd0);
    check_eq("ovr_cov",  32'(cov_mask), 32'h0001);
    check_eq("ovr_busy", 32'(busy), 32'd1);
    golden_vecs(1, 15);
    check_eq("ovr_done", 32'(done), 32'd1);
    check_eq("ovr_err2", 32'(err_cnt), 32'd0);
    check_eq("ovr_cov2", 32'(cov_mask), 32'hFFFF);
    check_eq("ovr_pass", 32'(pass), 32'd0);

    // Coverage hole: 16 x vector 0000
    pulse_start();
    check_eq("hole_ovr_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 16; i++) apply_vec(4'h0, 1'b1);
    check_eq("hole_done", 32'(done), 32'd1);
    check_eq("hole_err",  32'(err_cnt), 32'd0);
    check_eq("hole_cov",  32'(cov_mask), 32'h0001);
    check_eq("hole_pass", 32'(pass), 32'd0);

    // Latency, SETTLE_CYC=0: y wrong on the cycle after capture is sampled
    start0 = 1'b1; tick(); start0 = 1'b0;
    {a0, b0, c0, d0} = 4'hF; y0 = 1'b0; vec_valid0 = 1'b1;
    tick();
    vec_valid0 = 1'b0; y0 = 1'b1;
    tick();
    y0 = 1'b0;
    tick();
    check_eq("lat0_vec", 32'(vec_cnt0), 32'd1);
    check_eq("lat0_err", 32'(err_cnt0), 32'd1);
    check_eq("lat0_cov", 32'(cov_mask0), 32'h8000);

    // Latency, SETTLE_CYC=2: same glitch is settled out by the compare edge
    pulse_start();
    {a, b, c, d} = 4'hF; y = 1'b0; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0; y = 1'b1;
    tick();
    y = 1'b0;
    tick();
    check_eq("lat2_pending", 32'(vec_cnt), 32'd0);
    tick();
    check_eq("lat2_vec", 32'(vec_cnt), 32'd1);
    check_eq("lat2_err", 32'(err_cnt), 32'd0);

    // Reset mid-run after 5 vectors
    pulse_start();
    golden_vecs(0, 5);
    check_eq("pre_rst_vec", 32'(vec_cnt), 32'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("midrst");

    // start mid-SETTLE discards the pending check
    pulse_start();
    golden_vecs(0, 2);
    {a, b, c, d} = 4'h0; y = 1'b0; vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    tick();
    pulse_start();
    check_eq("abort_vec",  32'(vec_cnt), 32'd0);
    check_eq("abort_cov",  32'(cov_mask), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check_eq("abort_nochk_vec", 32'(vec_cnt), 32'd0);
    check_eq("abort_nochk_err", 32'(err_cnt), 32'd0);
    golden_vecs(0, 16);
    check_eq("regold_vec",  32'(vec_cnt), 32'd16);
    check_eq("regold_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
